ram_march_tester: RTL
=====================

// Module: ram_march_tester
// PURPOSE
//  Self-checking, parametrised RAM test engine. Replaces hand-coded per-address RAM read/write sequences.
//  On a rising edge of en it writes an address-derived pattern over [ADDR_LO..ADDR_HI], then reads it back and compares.
//  It then repeats the write and readback with the inverted pattern. fail/done go to the shared test-harness result bus.
// PARAMETERS
//  ADDR_W   15     RAM address width
//  DATA_W   8      RAM data width (1..32)
//  ADDR_LO  0      first address tested
//  ADDR_HI  32767  last address tested; ADDR_HI >= ADDR_LO
//  READ_LAT 1      cycles from the posedge that samples rd to the posedge where q is valid (1..4)
//  PATTERN  8'hAA  seed XORed into pattern; truncated or zero-extended to DATA_W
// PORTS
//  clk      in  1       clock, all logic on posedge
//  rst_n    in  1       asynchronous reset, active low
//  en       in  1       start request; rising edge (sampled 0 then 1) starts a run
//  fail     out 1       sticky mismatch flag
//  done     out 1       1 for one cycle at end of run, else 1'bz (shared bus)
//  a        out ADDR_W  RAM address
//  d        out DATA_W  RAM write data
//  wr       out 1       RAM write strobe
//  rd       out 1       RAM read strobe
//  q        in  DATA_W  RAM read data
//  err_addr out ADDR_W  address of first mismatch
//  err_data out DATA_W  q value at first mismatch
// BEHAVIOUR
//  - Reset (async, rst_n=0), applies immediately, also mid-run: state=IDLE, fail=0, done=z, a=0, d=0, wr=0, rd=0,
//    err_addr=0, err_data=0, compare pipeline cleared. No compare fires after reset release.
//  - n = ADDR_HI-ADDR_LO+1. Pattern P(x) = x[DATA_W-1:0] ^ PATTERN; pass 1 uses ~P(x).
//  - FSM: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> FIN -> IDLE.
//  - IDLE: wr=rd=0. en rise sampled at edge E: fail, err_addr and err_data cleared; state enters WR0.
//  - WRk: one write per cycle, a ascending from ADDR_LO, wr=1, d=P(a) (k=0) or ~P(a) (k=1); lasts exactly n cycles.
//  - RDk: rd=1 with ascending a for n cycles, then rd=0 for READ_LAT drain cycles; lasts n+READ_LAT cycles.
//    Expected value and address ride a READ_LAT-deep shift pipe.
//    q is compared on the edge where the pipe output is valid. Compare uses !== (X/Z on q is a mismatch).
//  - Mismatch: fail<=1. If fail was 0, err_addr and err_data are loaded. Later mismatches do not overwrite them.
//    The run continues to the end.
//  - FIN: done=1 for exactly one cycle, beginning 4n+2*READ_LAT cycles after E. State returns to IDLE and done=z.
//    fail holds until the next start.
//  - en changes while not IDLE are ignored. A rise needs en sampled low, so en held high does not retrigger.
//  - Address counter never wraps past ADDR_HI. n=1 is legal.
// CONFIGURATION
//  RAM_TEST_ERRLOG_EN defined:
//   - err_addr and err_data capture the first mismatch as above.
//   - Each mismatch is printed via $display as "ram::march pass <k> addr <a> exp <e> got <q>" (simulation only).
//  RAM_TEST_ERRLOG_EN undefined:
//   - err_addr and err_data are tied to 0 and nothing is printed.
//   - fail and done behaviour is identical in both builds.
// TESTING
//  1 Ideal RAM model, READ_LAT=1, range 1234..1236, pulse en: done high once, 14 cycles after E; fail=0.
//  2 RAM model with bit3 stuck at 0 at 1235, PATTERN=AA: fail=1; with RAM_TEST_ERRLOG_EN, err_addr=1235,
//    err_data=8'h71; done still asserted.
//  3 READ_LAT=3, range 0..32767, ideal RAM: fail=0, done 131078 cycles after E; last compare is address 32767.
//  4 rst_n pulsed low during RD0: all outputs at reset values asynchronously. No done afterwards.
//    Next en rise runs a clean pass.
//  5 en held high across FIN, then toggled mid-run: exactly one run completes, no retrigger.
//    After en falls and rises, a second run starts with fail cleared.
//  6 q driven X at 1236 (ADDR_LO=ADDR_HI=1236): fail=1, and done arrives 6 cycles after E.

Source files
------------

// File: rtl/ram_march_tester.sv
// Two-pass march RAM tester: writes P(x) = x ^ PATTERN, reads back, then repeats with ~P(x).
// Optional RAM_TEST_ERRLOG_EN keeps a first-mismatch log (err_addr/err_data) and prints each mismatch.
module ram_march_tester #(
    parameter int          ADDR_W   = 15,
    parameter int          DATA_W   = 8,
    parameter int          ADDR_LO  = 0,
    parameter int          ADDR_HI  = 32767,
    parameter int          READ_LAT = 1,
    parameter logic [31:0] PATTERN  = 32'h0000_00AA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              fail,
    output logic              done,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] d,
    output logic              wr,
    output logic              rd,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    localparam int                N       = ADDR_HI - ADDR_LO + 1;
    localparam int                CNT_W   = ADDR_W + 3;
    localparam logic [CNT_W-1:0]  N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0]  WR_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(N + READ_LAT - 1);
    localparam logic [DATA_W-1:0] SEED    = DATA_W'(PATTERN);

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  rd_exp;
    logic               en_q;
    logic               start;
    logic               mismatch;

    logic [READ_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0]   pipe_addr [READ_LAT];
    logic [DATA_W-1:0]   pipe_exp  [READ_LAT];

    // Address bits are zero-extended or truncated to the data width before the seed XOR.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] x);
        logic [DATA_W+ADDR_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, x};
        return wide[DATA_W-1:0] ^ SEED;
    endfunction

    assign cur_addr = ADDR_W'(ADDR_LO) + cnt[ADDR_W-1:0];

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        a          = '0;
        d          = '0;
        wr         = 1'b0;
        rd         = 1'b0;
        rd_exp     = '0;
        unique case (state)
            IDLE: begin
                if (en && !en_q) begin
                    state_next = WR0;
                    start      = 1'b1;
                end
            end
            WR0, WR1: begin
                wr = 1'b1;
                a  = cur_addr;
                d  = (state == WR1) ? ~pattern(cur_addr) : pattern(cur_addr);
                if (cnt == WR_LAST) state_next = (state == WR0) ? RD0 : RD1;
            end
            RD0, RD1: begin
                // Reads stop after n cycles; the remaining READ_LAT cycles drain the compare pipe.
                if (cnt < N_CNT) begin
                    rd     = 1'b1;
                    a      = cur_addr;
                    rd_exp = (state == RD1) ? ~pattern(cur_addr) : pattern(cur_addr);
                end
                if (cnt == RD_LAST) state_next = (state == RD0) ? WR1 : FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            // Held high through reset so a level already high at release is not taken as a rise.
            en_q  <= 1'b1;
        end else begin
            state <= state_next;
            en_q  <= en;
            if (state_next != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: the compare pipe is a handful of flops, so it is reset; no stale entry survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd;
            pipe_addr[0] <= a;
            pipe_exp[0]  <= rd_exp;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    // Case inequality so an X or Z on q counts as a mismatch in simulation.
    assign mismatch = pipe_vld[READ_LAT-1] && (q !== pipe_exp[READ_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        fail <= 1'b0;
        else if (start)    fail <= 1'b0;
        else if (mismatch) fail <= 1'b1;
    end

    // Shared result bus: drive only during the single FIN cycle.
    assign done = (state == FIN) ? 1'b1 : 1'bz;

`ifdef RAM_TEST_ERRLOG_EN
    logic [READ_LAT-1:0] pipe_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_pass <= '0;
        end else begin
            pipe_pass[0] <= (state == RD1);
            for (int i = 1; i < READ_LAT; i++) pipe_pass[i] <= pipe_pass[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_data <= '0;
        end else if (start) begin
            err_addr <= '0;
            err_data <= '0;
        end else if (mismatch) begin
            if (!fail) begin
                err_addr <= pipe_addr[READ_LAT-1];
                err_data <= q;
            end
            $display("ram::march pass %0d addr %0d exp %0h got %0h",
                     pipe_pass[READ_LAT-1], pipe_addr[READ_LAT-1], pipe_exp[READ_LAT-1], q);
        end
    end
`else
    assign err_addr = '0;
    assign err_data = '0;
`endif

endmodule
